// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with a fixed-priority encoder
// and a claim / end-of-interrupt handshake.
//
// Ports
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   cs, wen, addr    : bus select, write enable, 3-bit register select
//   din              : bus write data (WIDTH)
//   dout             : combinational read data for the selected register
//   irq_in           : interrupt request lines (NIRQ), synchronous to clk
//   irq              : registered interrupt request to the CPU
//   vector           : in-service line while servicing, else highest pending
//
// Register map: 0 PEND (R, W1C), 1 MASK, 2 MODE (1=edge, 0=level),
// 3 VECT (R), 4 CLAIM (W), 5 EOI (W), 6 SET (W1S), 7 STAT (R).
// VECT and STAT place fields up to bit 31, so WIDTH is expected to be >= 32.
module irq_ctrl #(
  parameter int WIDTH = 32,
  parameter int NIRQ  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wen,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic [NIRQ-1:0]  irq_in,
  output logic             irq,
  output logic [4:0]       vector
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [2:0] A_PEND  = 3'd0;
  localparam logic [2:0] A_MASK  = 3'd1;
  localparam logic [2:0] A_MODE  = 3'd2;
  localparam logic [2:0] A_VECT  = 3'd3;
  localparam logic [2:0] A_CLAIM = 3'd4;
  localparam logic [2:0] A_EOI   = 3'd5;
  localparam logic [2:0] A_SET   = 3'd6;
  localparam logic [2:0] A_STAT  = 3'd7;

  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [NIRQ-1:0] mode_q, mode_d;
  logic [NIRQ-1:0] prev_q, prev_d;
  state_t          state_q, state_d;
  logic [4:0]      isr_q, isr_d;
  logic            irq_q, irq_d;

  logic            wr;
  logic [NIRQ-1:0] active;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] clr;
  logic [NIRQ-1:0] setb;
  logic [NIRQ-1:0] pend_edge;
  logic [4:0]      hp_idx;
  logic            any_act;
  logic            claim;

  // din bits above NIRQ are never stored
  logic unused_din;
  assign unused_din = ^din;

  // Lowest index wins: scan high to low so the last hit is the smallest.
  always_comb begin
    active  = pend_q & mask_q;
    any_act = |active;
    hp_idx  = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (active[i]) hp_idx = 5'(i);
    end
  end

  always_comb begin
    wr    = cs & wen;
    rise  = irq_in & ~prev_q;
    claim = wr && (addr == A_CLAIM) && (state_q == S_ASSERT) && any_act;
    clr   = (wr && addr == A_PEND) ? din[NIRQ-1:0] : '0;
    if (claim) clr = clr | (NIRQ'(1) << hp_idx);
    setb  = (wr && addr == A_SET) ? din[NIRQ-1:0] : '0;
    // Sets are OR-ed in after the clear so a same-cycle edge/SET survives.
    pend_edge = (pend_q & ~clr) | rise | setb;
    // Level-mode bits simply track the sampled input.
    pend_d = (mode_q & pend_edge) | (~mode_q & irq_in);
    prev_d = irq_in;
    mask_d = (wr && addr == A_MASK) ? din[NIRQ-1:0] : mask_q;
    mode_d = (wr && addr == A_MODE) ? din[NIRQ-1:0] : mode_q;
  end

  always_comb begin
    state_d = state_q;
    isr_d   = isr_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_act) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (claim) begin
          state_d = S_SERVICE;
          isr_d   = hp_idx;
        end else if (!any_act) begin
          state_d = S_IDLE;
        end
      end
      S_SERVICE: begin
        // In-service index is only meaningful while servicing.
        if (wr && addr == A_EOI) begin
          state_d = S_IDLE;
          isr_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    irq_d = (state_d == S_ASSERT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '1;
      prev_q  <= '0;
      state_q <= S_IDLE;
      isr_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      isr_q   <= isr_d;
      irq_q   <= irq_d;
    end
  end

  assign irq    = irq_q;
  assign vector = (state_q == S_SERVICE) ? isr_q : hp_idx;

  always_comb begin
    dout = '0;
    unique case (addr)
      A_PEND: dout[NIRQ-1:0] = pend_q;
      A_MASK: dout[NIRQ-1:0] = mask_q;
      A_MODE: dout[NIRQ-1:0] = mode_q;
      A_VECT: begin
        dout[31]  = any_act || (state_q == S_SERVICE);
        dout[4:0] = vector;
      end
      A_STAT: begin
        dout[1:0]  = state_q;
        dout[12:8] = isr_q;
      end
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (NIRQ=8 so unimplemented upper bits are visible).
// Stimulus pushes expected values into a queue; a monitor pops and compares.
module tb_irq_ctrl;
  localparam int WIDTH = 32;
  localparam int NIRQ  = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cs = 1'b0;
  logic             wen = 1'b0;
  logic [2:0]       addr = 3'd0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic [NIRQ-1:0]  irq_in = '0;
  logic             irq;
  logic [4:0]       vector;

  irq_ctrl #(.WIDTH(WIDTH), .NIRQ(NIRQ)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr), .din(din),
    .dout(dout), .irq_in(irq_in), .irq(irq), .vector(vector)
  );

  always #20 clk = ~clk;

  typedef struct {
    int          kind;   // 0 dout, 1 irq, 2 vector
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t q[$];
  logic smp = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Monitor: every toggle of smp means fresh expectations are queued.
  always @(smp) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = dout;
        1:       act = {31'd0, irq};
        default: act = {27'd0, vector};
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wen = 1'b1; addr = a; din = d;
    tick();
    cs = 1'b0; wen = 1'b0; din = '0;
  endtask

  task automatic push(input int k, input logic [31:0] e, input string nm);
    q.push_back('{kind: k, exp: e, nm: nm});
    smp = ~smp;
    #1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    addr = a;
    #1;
    push(0, e, nm);
  endtask

  task automatic chk_irq(input logic e, input string nm);
    push(1, {31'd0, e}, nm);
  endtask

  task automatic chk_vec(input logic [4:0] e, input string nm);
    push(2, {27'd0, e}, nm);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    // reset values
    rd(0, 32'h0, "rst_pend");
    rd(1, 32'h0, "rst_mask");
    rd(2, 32'h0000_00FF, "rst_mode");
    rd(7, 32'h0, "rst_stat");
    rd(3, 32'h0, "rst_vect");
    chk_irq(1'b0, "rst_irq");

    // edge pulse on line 2 with MASK=0x5
    wr(1, 32'h5);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    rd(0, 32'h4, "pulse_pend");
    chk_irq(1'b0, "pulse_irq_early");
    tick();
    chk_irq(1'b1, "pulse_irq");
    rd(3, 32'h8000_0002, "pulse_vect");
    rd(7, 32'h1, "pulse_stat_assert");

    // lines 0 and 2 pending -> claim 0, EOI, re-assert with 2
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    rd(0, 32'h5, "two_pend");
    chk_vec(5'd0, "two_vec");
    wr(4, 32'h0);
    rd(7, 32'h2, "claim_stat");
    rd(0, 32'h4, "claim_pend");
    rd(3, 32'h8000_0000, "claim_vect");
    chk_irq(1'b0, "claim_irq");
    wr(5, 32'h0);
    rd(7, 32'h0, "eoi_stat");
    chk_irq(1'b0, "eoi_irq");
    tick();
    rd(7, 32'h1, "reassert_stat");
    chk_irq(1'b1, "reassert_irq");
    chk_vec(5'd2, "reassert_vec");
    wr(4, 32'h0);
    rd(7, 32'h202, "claim2_stat");
    rd(0, 32'h0, "claim2_pend");
    wr(5, 32'h0);
    tick();
    rd(7, 32'h0, "idle_stat");
    wr(4, 32'h0);
    rd(7, 32'h0, "claim_idle_ignored");

    // set wins over W1C on same cycle; plain W1C, SET
    irq_in = 8'h08;
    wr(0, 32'h8);
    irq_in = 8'h00;
    rd(0, 32'h8, "setwins_pend");
    wr(0, 32'h8);
    rd(0, 32'h0, "w1c_pend");
    wr(6, 32'h10);
    rd(0, 32'h10, "set_pend");
    wr(0, 32'h10);
    rd(0, 32'h0, "w1c2_pend");
    // write without cs is ignored; upper bits read 0
    cs = 1'b0; wen = 1'b1; addr = 3'd1; din = 32'hFFFF_FFFF;
    tick();
    wen = 1'b0;
    rd(1, 32'h5, "nocs_mask");
    wr(1, 32'hFFFF_FF05);
    rd(1, 32'h0000_0005, "mask_upper_zero");

    // level mode
    wr(2, 32'h0);
    wr(1, 32'h1);
    irq_in = 8'h01;
    tick();
    rd(0, 32'h1, "lvl_pend");
    chk_irq(1'b0, "lvl_irq_early");
    tick();
    chk_irq(1'b1, "lvl_irq");
    wr(0, 32'h1);
    rd(0, 32'h1, "lvl_w1c_ignored");
    wr(6, 32'h2);
    rd(0, 32'h1, "lvl_set_ignored");
    irq_in = 8'h00;
    tick(); tick();
    rd(0, 32'h0, "lvl_drop_pend");
    chk_irq(1'b0, "lvl_drop_irq");
    rd(7, 32'h0, "lvl_drop_stat");

    // mask removal in ASSERT, then claim ignored
    wr(2, 32'hFF);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    chk_irq(1'b1, "mask_irq_before");
    wr(1, 32'h0);
    tick();
    rd(7, 32'h0, "mask_stat_idle");
    chk_irq(1'b0, "mask_irq_after");
    wr(4, 32'h0);
    rd(7, 32'h0, "mask_claim_ignored");
    rd(0, 32'h1, "mask_pend_kept");

    // reset during SERVICE with line 1 high and a simultaneous write
    wr(1, 32'h1);
    tick();
    rd(7, 32'h1, "pre_rst_assert");
    wr(4, 32'h0);
    rd(7, 32'h2, "pre_rst_service");
    irq_in = 8'h02;
    reset = 1'b1;
    cs = 1'b1; wen = 1'b1; addr = 3'd1; din = 32'hF;
    tick();
    cs = 1'b0; wen = 1'b0; din = '0;
    tick();
    reset = 1'b0;
    rd(0, 32'h0, "rst2_pend");
    rd(1, 32'h0, "rst2_mask");
    rd(2, 32'h0000_00FF, "rst2_mode");
    rd(7, 32'h0, "rst2_stat");
    chk_irq(1'b0, "rst2_irq");
    tick();
    rd(0, 32'h2, "rst2_edge_pend");
    chk_irq(1'b0, "rst2_irq_masked");
    chk_vec(5'd0, "rst2_vec");
    tick();
    chk_irq(1'b0, "rst2_irq_later");
    rd(7, 32'h0, "rst2_stat_later");
    irq_in = 8'h00;

    #5;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, bus data width.
REQ-002 Parameter NIRQ, default 32, number of interrupt inputs (1..WIDTH).
REQ-003 clk  input  1  system clock, all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cs  input  1  chip select from address decoder.
REQ-006 wen  input  1  bus write enable; a write occurs on a clk edge with cs=1 and wen=1.
REQ-007 addr  input  3  register select.
REQ-008 din  input  WIDTH  bus write data.
REQ-009 dout  output  WIDTH  bus read data, combinational from addr and registers.
REQ-010 irq_in  input  NIRQ  interrupt request lines, synchronous to clk.
REQ-011 irq  output  1  registered interrupt request to CPU.
REQ-012 vector  output  5  index of the in-service (SERVICE state) or highest-priority pending line (otherwise).

Function
REQ-013 Registers: 0 PEND (R; W1C), 1 MASK (R/W), 2 MODE (R/W; 1=edge, 0=level), 3 VECT (R), 4 CLAIM (W), 5 EOI (W), 6 SET (W1S to PEND), 7 STAT (R); bits above NIRQ read 0.
REQ-014 Edge mode: a rising edge is irq_in[i]=1 while the previous-cycle sample prev[i]=0; it sets PEND[i] on the next edge.
REQ-015 Level mode: PEND[i] equals the registered irq_in[i]; W1C and SET do not affect level-mode bits.
REQ-016 Set wins: a new edge or SET on line i in the same cycle as a W1C/claim clear of i leaves PEND[i]=1.
REQ-017 Active set = PEND & MASK; priority fixed, lowest index highest.
REQ-018 VECT read: bit 31 = valid (active set non-zero, or state SERVICE), bits 4:0 = vector.
REQ-019 STAT read: bits 1:0 = state (0 IDLE, 1 ASSERT, 2 SERVICE), bits 12:8 = in-service index.
REQ-020 FSM IDLE: irq=0; on a clk edge with non-empty active set go to ASSERT; irq=1 from the following cycle.
REQ-021 FSM ASSERT: if the active set becomes empty (mask or W1C) return to IDLE, irq=0 next cycle; a write to CLAIM latches the current highest-priority index as in-service, clears its PEND bit (edge mode), goes to SERVICE, irq=0.
REQ-022 FSM SERVICE: irq held 0; no nesting; write to EOI returns to IDLE; a still-active set re-enters ASSERT one cycle later.
REQ-023 CLAIM in IDLE or SERVICE and EOI outside SERVICE are ignored.
REQ-024 MASK/MODE writes take effect on the following cycle; changing MODE does not clear PEND.
REQ-025 Writes without cs, and reads, have no side effects.

Reset
REQ-026 On reset: PEND=0, MASK=0, MODE=all ones (edge), prev=0, state IDLE, in-service index 0, irq=0.
REQ-027 Reset mid-SERVICE or mid-ASSERT discards claim state immediately; prev=0 means a line held high through reset registers one edge after release.
REQ-028 Reset takes priority over simultaneous bus writes.

Verification
REQ-029 MASK=0x5, pulse irq_in[2] one cycle -> PEND=0x4, irq=1 two cycles after pulse, VECT=0x80000002.
REQ-030 Pending lines 0 and 2 enabled, write CLAIM -> in-service 0, PEND=0x4, irq=0; write EOI -> ASSERT again, vector 2.
REQ-031 Same-cycle edge on line 3 and W1C of bit 3 -> PEND[3]=1.
REQ-032 MODE=0, MASK=0x1, irq_in[0] held high, W1C bit 0 -> PEND stays 0x1; drop input -> PEND=0 and irq=0 within two cycles.
REQ-033 MASK=0x1, ASSERT state, write MASK=0 -> IDLE, irq=0 next cycle; CLAIM then ignored (STAT=0).
REQ-034 Assert reset during SERVICE with irq_in[1] high -> all registers at reset values; after release PEND[1]=1 (edge mode) and irq stays 0 (MASK=0).
